keypoint_reader: RTL

//  Reads back the keypoint lists written by detection/filtering into the two keypoint SRAMs
//  (DoG layer pair 1 and layer pair 2). Each list is replayed as one valid/ready stream

---
 rtl/keypoint_reader_if.sv | 20 ++
 rtl/keypoint_reader.sv | 110 +++++++++++
 2 files changed

// File: rtl/keypoint_reader_if.sv
// keypoint_reader_if: valid/ready keypoint stream from the reader to the orientation/descriptor stage
//   valid  master->slave  head keypoint present
//   ready  slave->master  downstream accepts on valid&ready
//   row    master->slave  keypoint row
//   col    master->slave  keypoint column
//   layer  master->slave  0 = DoG layer pair 1, 1 = layer pair 2
//   last   master->slave  final keypoint of the readout
interface keypoint_reader_if #(
  parameter int ROW_W = 9,
  parameter int COL_W = 10
);
  logic             valid;
  logic             ready;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             layer;
  logic             last;
  modport master (output valid, row, col, layer, last, input ready);
  modport slave (input valid, row, col, layer, last, output ready);
endinterface

// File: rtl/keypoint_reader.sv
// keypoint_reader: replays keypoint SRAM 1 then SRAM 2 as one valid/ready stream
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 readout start pulse, sampled in IDLE
//   kp1_count, kp2_count  entries per SRAM, saturated to 2**ADDR_W, latched on start
//   kpN_addr/kpN_re       SRAM read address/strobe; kpN_dout valid the cycle after kpN_re
//   kp                    output keypoint stream (master side)
//   busy, done            readout in progress, 1-cycle completion pulse
module keypoint_reader #(
  parameter int ADDR_W     = 11,
  parameter int CNT_W      = 12,
  parameter int ROW_W      = 9,
  parameter int COL_W      = 10,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CNT_W-1:0]       kp1_count,
  input  logic [CNT_W-1:0]       kp2_count,
  output logic [ADDR_W-1:0]      kp1_addr,
  output logic                   kp1_re,
  input  logic [ROW_W+COL_W-1:0] kp1_dout,
  output logic [ADDR_W-1:0]      kp2_addr,
  output logic                   kp2_re,
  input  logic [ROW_W+COL_W-1:0] kp2_dout,
  keypoint_reader_if.master      kp,
  output logic                   busy,
  output logic                   done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  localparam int DW = ROW_W + COL_W;
  localparam logic [CNT_W-1:0] MAXN = CNT_W'(1 << ADDR_W);

  typedef enum logic [2:0] {IDLE, RD1, RD2, DRAIN, DONE} state_t;

  state_t state, state_n;
  logic [CNT_W-1:0] n1, n2, s1, s2;
  logic [DW+1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [OW-1:0] occ, occ_n;
  logic pend, pend_layer, pend_last;
  logic pop, room, end1, end2, lst;

  // pend marks SRAM data arriving this cycle; the room test counts it, so a
  // read is only launched when its word is guaranteed a FIFO slot.
  always_comb begin
    s1 = kp1_count > MAXN ? MAXN : kp1_count;
    s2 = kp2_count > MAXN ? MAXN : kp2_count;
    pop = kp.valid && kp.ready;
    occ_n = occ + OW'(pend) - OW'(pop);
    room = occ_n < OW'(FIFO_DEPTH);
    end1 = CNT_W'(kp1_addr) == n1 - CNT_W'(1);
    end2 = CNT_W'(kp2_addr) == n2 - CNT_W'(1);
    kp1_re = state == RD1 && room;
    kp2_re = state == RD2 && room;
    lst = (kp1_re && end1 && n2 == '0) || (kp2_re && end2);
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = s1 != '0 ? RD1 : s2 != '0 ? RD2 : DONE;
      RD1:     if (kp1_re && end1) state_n = n2 != '0 ? RD2 : DRAIN;
      RD2:     if (kp2_re && end2) state_n = DRAIN;
      DRAIN:   if (occ_n == '0) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  assign kp.valid = occ != '0;
  assign {kp.last, kp.layer, kp.row, kp.col} = mem[rp];
  assign busy = state != IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      n1 <= '0;
      n2 <= '0;
      kp1_addr <= '0;
      kp2_addr <= '0;
      pend <= 1'b0;
      pend_layer <= 1'b0;
      pend_last <= 1'b0;
      wp <= '0;
      rp <= '0;
      occ <= '0;
      done <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_n;
      done <= state == DONE;
      pend <= kp1_re || kp2_re;
      pend_layer <= kp2_re;
      pend_last <= lst;
      occ <= occ_n;
      if (state == IDLE && start) begin
        n1 <= s1;
        n2 <= s2;
        kp1_addr <= '0;
        kp2_addr <= '0;
      end
      // addresses stop on the final entry so a full 2K list never wraps
      if (kp1_re && !end1) kp1_addr <= kp1_addr + 1'b1;
      if (kp2_re && !end2) kp2_addr <= kp2_addr + 1'b1;
      if (pend) begin
        mem[wp] <= {pend_last, pend_layer, pend_layer ? kp2_dout : kp1_dout};
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
    end
  end
endmodule
